gcn_result_collector: RTL and testbench

//  Sits directly downstream of the gcn top. It captures the per-node argmax class labels written on
//  y/output_addr/output_we into an internal label table. Once gcn done is seen, it replays the

---
 rtl/gcn_result_collector.sv | 112 +++++++++++
 tb/tb_gcn_result_collector.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcn_result_collector.sv
// Captures per-node argmax labels from the gcn write port, then replays them in node order as a stream.
// Latency: first beat valid the cycle after gcn_done; one beat per cycle; done pulses after the last handshake.
// Backpressure: m_ready low holds the current beat stable; m_valid stays high until the beat is accepted.
module gcn_result_collector #(
    parameter int NUM_OUTS  = 6,
    parameter int NUM_NODES = 6,
    parameter int LABEL_W   = 3,
    parameter int ADDR_W    = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               output_we,
    input  logic [NUM_OUTS-1:0][ADDR_W-1:0]    output_addr,
    input  logic [NUM_OUTS-1:0][LABEL_W-1:0]   y,
    input  logic                               gcn_done,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [ADDR_W-1:0]                  m_node,
    output logic [LABEL_W-1:0]                 m_class,
    output logic                               m_missing,
    output logic                               addr_err,
    output logic                               busy,
    output logic                               done
);

    localparam logic [ADDR_W:0]   NODE_CNT  = (ADDR_W+1)'(NUM_NODES);
    localparam logic [ADDR_W-1:0] LAST_NODE = ADDR_W'(NUM_NODES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t                             state;
    state_t                             state_nxt;
    logic [NUM_NODES-1:0][LABEL_W-1:0]  label_q;
    logic [NUM_NODES-1:0]               written_q;
    logic [ADDR_W-1:0]                  rd_ptr;
    logic                               drain_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = COLLECT;
            COLLECT: if (gcn_done) state_nxt = DRAIN;
            DRAIN:   if (m_ready && rd_ptr == LAST_NODE) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lanes are visited in ascending order, so the highest lane's non-blocking write lands last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            label_q   <= '0;
            written_q <= '0;
            rd_ptr    <= '0;
            addr_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        written_q <= '0;
                        addr_err  <= 1'b0;
                        rd_ptr    <= '0;
                    end
                end
                COLLECT: begin
                    if (output_we) begin
                        for (int i = 0; i < NUM_OUTS; i++) begin
                            if ({1'b0, output_addr[i]} < NODE_CNT) begin
                                label_q[output_addr[i]]   <= y[i];
                                written_q[output_addr[i]] <= 1'b1;
                            end else begin
                                addr_err <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (m_ready && rd_ptr != LAST_NODE) begin
                        rd_ptr <= rd_ptr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat fields decode only flops, and are forced to zero outside DRAIN.
    always_comb begin
        drain_act = (state == DRAIN);
        m_valid   = drain_act;
        m_node    = drain_act ? rd_ptr : '0;
        m_class   = (drain_act && written_q[rd_ptr]) ? label_q[rd_ptr] : '0;
        m_missing = drain_act && !written_q[rd_ptr];
        done      = (state == FINISH);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_gcn_result_collector.sv
// Directed bench for gcn_result_collector: a label-table model fills a scoreboard of expected
// beats at gcn_done, and the drain loop pops and compares each accepted beat.
module tb_gcn_result_collector;

    localparam int NUM_OUTS  = 6;
    localparam int NUM_NODES = 6;
    localparam int LABEL_W   = 3;
    localparam int ADDR_W    = 3;

    logic clk = 1'b0;
    logic rst_n, start, output_we, gcn_done, m_ready;
    logic [NUM_OUTS-1:0][ADDR_W-1:0]  output_addr;
    logic [NUM_OUTS-1:0][LABEL_W-1:0] y;
    logic                             m_valid, m_missing, addr_err, busy, done;
    logic [ADDR_W-1:0]                m_node;
    logic [LABEL_W-1:0]               m_class;

    typedef struct packed {
        logic [ADDR_W-1:0]  node;
        logic [LABEL_W-1:0] cls;
        logic               missing;
    } beat_t;

    beat_t              sb[$];
    logic [LABEL_W-1:0] mdl_label   [NUM_NODES];
    logic               mdl_written [NUM_NODES];
    logic               mdl_err;
    int                 pa [NUM_OUTS];
    int                 pv [NUM_OUTS];
    int                 n_tests = 0;
    int                 n_fail  = 0;

    gcn_result_collector #(
        .NUM_OUTS(NUM_OUTS), .NUM_NODES(NUM_NODES), .LABEL_W(LABEL_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .output_we(output_we),
        .output_addr(output_addr), .y(y), .gcn_done(gcn_done),
        .m_valid(m_valid), .m_ready(m_ready), .m_node(m_node), .m_class(m_class),
        .m_missing(m_missing), .addr_err(addr_err), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        beat_t b;
        for (int n = 0; n < NUM_NODES; n++) begin
            b.node    = ADDR_W'(n);
            b.cls     = mdl_written[n] ? mdl_label[n] : '0;
            b.missing = ~mdl_written[n];
            sb.push_back(b);
        end
    endtask

    task automatic tb_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < NUM_NODES; n++) mdl_written[n] = 1'b0;
        mdl_err = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic write_beat(input bit with_done);
        for (int i = 0; i < NUM_OUTS; i++) begin
            output_addr[i] = ADDR_W'(pa[i]);
            y[i]           = LABEL_W'(pv[i]);
            if (pa[i] < NUM_NODES) begin
                mdl_label[pa[i]]   = LABEL_W'(pv[i]);
                mdl_written[pa[i]] = 1'b1;
            end else begin
                mdl_err = 1'b1;
            end
        end
        output_we = 1'b1;
        gcn_done  = with_done;
        tick();
        output_we = 1'b0;
        gcn_done  = 1'b0;
        if (with_done) begin
            push_expected();
            check("first_valid_same_cycle", 32'(m_valid), 32'd1);
        end
    endtask

    task automatic end_collect();
        check("collect_no_valid", 32'(m_valid), 32'd0);
        gcn_done = 1'b1;
        tick();
        gcn_done = 1'b0;
        push_expected();
        check("first_valid", 32'(m_valid), 32'd1);
    endtask

    // mode 0: always ready; mode 1: ready 1,0,0 repeating. poke drives start/output_we mid-drain.
    task automatic drain(input int mode, input int stop_after, input bit poke);
        int    cyc = 0;
        int    got = 0;
        bit    stalled = 1'b0;
        bit    rdy;
        beat_t held;
        beat_t e;
        while (got < stop_after) begin
            if (cyc >= 200) begin
                check("drain_timeout_beats", 32'(got), 32'(stop_after));
                break;
            end
            if (stalled) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_beat", 32'({m_node, m_class, m_missing}), 32'(held));
            end
            rdy         = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            start       = poke && (cyc == 2);
            output_we   = poke && (cyc == 2);
            output_addr = '1;
            y           = '1;
            m_ready     = rdy;
            if (m_valid && rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat_node", 32'(m_node), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("beat_node", 32'(m_node), 32'(e.node));
                    check("beat_class", 32'(m_class), 32'(e.cls));
                    check("beat_missing", 32'(m_missing), 32'(e.missing));
                end
                got++;
            end
            stalled = m_valid && !rdy;
            held    = {m_node, m_class, m_missing};
            tick();
            cyc++;
        end
        m_ready   = 1'b0;
        start     = 1'b0;
        output_we = 1'b0;
    endtask

    task automatic post_drain();
        check("done_pulse", 32'(done), 32'd1);
        check("finish_no_valid", 32'(m_valid), 32'd0);
        check("finish_addr_err", 32'(addr_err), 32'(mdl_err));
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_addr_err", 32'(addr_err), 32'(mdl_err));
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic t1_pattern();
        pa = '{0, 1, 2, 3, 4, 5};
        pv = '{0, 1, 2, 2, 1, 0};
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; output_we = 1'b0; gcn_done = 1'b0; m_ready = 1'b0;
        output_addr = '0; y = '0; mdl_err = 1'b0;
        for (int n = 0; n < NUM_NODES; n++) begin
            mdl_label[n]   = '0;
            mdl_written[n] = 1'b0;
        end
        #12;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_node", 32'(m_node), 32'd0);
        check("rst_m_class", 32'(m_class), 32'd0);
        check("rst_m_missing", 32'(m_missing), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        #5 rst_n = 1'b1;
        tick();

        // Writes and gcn_done in IDLE are ignored.
        output_addr = '1; y = '1; output_we = 1'b1; gcn_done = 1'b1;
        tick();
        output_we = 1'b0; gcn_done = 1'b0;
        check("idle_we_busy", 32'(busy), 32'd0);
        check("idle_we_addr_err", 32'(addr_err), 32'd0);

        // T1 basic
        tb_start();
        t1_pattern();
        write_beat(1'b0);
        end_collect();
        drain(0, NUM_NODES, 1'b0);
        post_drain();

        // T2 backpressure, entered by start+gcn_done together in IDLE
        start = 1'b1; gcn_done = 1'b1;
        tick();
        start = 1'b0; gcn_done = 1'b0;
        for (int n = 0; n < NUM_NODES; n++) mdl_written[n] = 1'b0;
        mdl_err = 1'b0;
        check("start_done_busy", 32'(busy), 32'd1);
        check("start_done_no_valid", 32'(m_valid), 32'd0);
        tick();
        check("start_done_still_collect", 32'(m_valid), 32'd0);
        t1_pattern();
        write_beat(1'b0);
        end_collect();
        drain(1, NUM_NODES, 1'b0);
        post_drain();

        // T3 missing nodes and overwrite
        tb_start();
        pa = '{0, 0, 2, 2, 5, 5};
        pv = '{1, 2, 4, 5, 6, 7};
        write_beat(1'b0);
        pa = '{2, 2, 2, 2, 2, 2};
        pv = '{3, 3, 3, 3, 3, 3};
        write_beat(1'b0);
        end_collect();
        drain(0, NUM_NODES, 1'b0);
        post_drain();

        // T4 lane conflict and out-of-range address
        tb_start();
        pa = '{7, 3, 0, 1, 3, 5};
        pv = '{4, 1, 6, 5, 2, 3};
        write_beat(1'b0);
        check("t4_addr_err", 32'(addr_err), 32'd1);
        end_collect();
        drain(1, NUM_NODES, 1'b0);
        post_drain();

        // T5 write and gcn_done in the same cycle; start clears addr_err
        tb_start();
        check("t5_addr_err_cleared", 32'(addr_err), 32'd0);
        pa = '{5, 4, 3, 2, 1, 0};
        pv = '{7, 6, 5, 4, 3, 2};
        write_beat(1'b1);
        drain(0, NUM_NODES, 1'b0);
        post_drain();

        // T6 reset mid-drain, then ignored start/write during a later drain
        tb_start();
        t1_pattern();
        write_beat(1'b0);
        end_collect();
        drain(0, 3, 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_m_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        #2 rst_n = 1'b1;
        tick();
        check("after_abort_done", 32'(done), 32'd0);
        tb_start();
        t1_pattern();
        write_beat(1'b0);
        end_collect();
        drain(1, NUM_NODES, 1'b1);
        post_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
